// File: rtl/mlp_inference_ctrl.sv
// MLP inference sequencer: launches the MLP, waits for done with a timeout, then runs a serial
// signed argmax over the captured activations. Optional low-confidence flag via MLP_CONF_CHECK_EN.
module mlp_inference_ctrl #(
    parameter int unsigned OL_NEURONS = 10,
    parameter int unsigned RESOLUTION = 8,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned TIMEOUT    = 1024
`ifdef MLP_CONF_CHECK_EN
    ,
    parameter logic signed [RESOLUTION-1:0] MIN_CONF = 8'sd64
`endif
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               MLP_go,
    input  logic                               MLP_done,
    input  logic [RESOLUTION*OL_NEURONS-1:0]   output_activations,
    output logic [DIGIT_W-1:0]                 digit,
    output logic signed [RESOLUTION-1:0]       max_activation,
    output logic                               result_valid,
    input  logic                               result_ack,
    output logic                               error,
    output logic                               low_conf
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);
    localparam logic [DIGIT_W-1:0] LAST_IDX  = DIGIT_W'(OL_NEURONS - 1);

    typedef enum logic [2:0] {IDLE, GO, WAIT, SCAN, DONE} state_t;

    state_t                       state_q, state_d;
    logic [TIMER_W-1:0]           timer_q, timer_d;
    logic [DIGIT_W-1:0]           idx_q, idx_d;
    logic [DIGIT_W-1:0]           best_idx_q, best_idx_d;
    logic [DIGIT_W-1:0]           digit_q, digit_d;
    logic signed [RESOLUTION-1:0] best_q, best_d;
    logic signed [RESOLUTION-1:0] max_q, max_d;
    logic signed [RESOLUTION-1:0] cur_act;
    logic signed [RESOLUTION-1:0] act_q [OL_NEURONS];
    logic signed [RESOLUTION-1:0] act_d [OL_NEURONS];
    logic                         error_q, error_d;
    logic                         busy_q, go_q, valid_q;
`ifdef MLP_CONF_CHECK_EN
    logic                         low_conf_q, low_conf_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, capture and serial argmax
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        digit_d    = digit_q;
        max_d      = max_q;
        error_d    = error_q;
        act_d      = act_q;
        cur_act    = act_q[idx_q];
`ifdef MLP_CONF_CHECK_EN
        low_conf_d = low_conf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = GO;
            end
            GO: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (MLP_done) begin
                    for (int i = 0; i < int'(OL_NEURONS); i++) begin
                        act_d[i] = output_activations[RESOLUTION*i +: RESOLUTION];
                    end
                    idx_d   = '0;
                    state_d = SCAN;
                end else if (timer_q == TIMER_MAX) begin
                    state_d = DONE;
                    error_d = 1'b1;
                    digit_d = '0;
                    max_d   = '0;
`ifdef MLP_CONF_CHECK_EN
                    low_conf_d = 1'b0;
`endif
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            SCAN: begin
                // Strictly-greater replace keeps the lowest index on ties
                if (idx_q == '0 || cur_act > best_q) begin
                    best_d     = cur_act;
                    best_idx_d = idx_q;
                end
                idx_d = idx_q + DIGIT_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    digit_d = best_idx_d;
                    max_d   = best_d;
`ifdef MLP_CONF_CHECK_EN
                    low_conf_d = (best_d < MIN_CONF);
`endif
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d = IDLE;
                    error_d = 1'b0;
`ifdef MLP_CONF_CHECK_EN
                    low_conf_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            digit_q    <= '0;
            max_q      <= '0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
            valid_q    <= 1'b0;
            for (int i = 0; i < int'(OL_NEURONS); i++) act_q[i] <= '0;
`ifdef MLP_CONF_CHECK_EN
            low_conf_q <= 1'b0;
`endif
        end else begin
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            digit_q    <= digit_d;
            max_q      <= max_d;
            error_q    <= error_d;
            busy_q     <= (state_d != IDLE);
            go_q       <= (state_d == GO);
            valid_q    <= (state_d == DONE);
            act_q      <= act_d;
`ifdef MLP_CONF_CHECK_EN
            low_conf_q <= low_conf_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign MLP_go         = go_q;
    assign result_valid   = valid_q;
    assign digit          = digit_q;
    assign max_activation = max_q;
    assign error          = error_q;
`ifdef MLP_CONF_CHECK_EN
    assign low_conf       = low_conf_q;
`else
    assign low_conf       = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_inference_ctrl.sv
// Testbench for mlp_inference_ctrl: directed and randomized inferences checked against an
// argmax/latency reference model. Honours MLP_CONF_CHECK_EN for the low_conf expectation.
module tb_mlp_inference_ctrl;
    localparam int unsigned N  = 10;
    localparam int unsigned R  = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned TO = 16;

    logic                clk = 1'b0;
    logic                reset, start, MLP_done, result_ack;
    logic [R*N-1:0]      output_activations;
    logic                busy, MLP_go, result_valid, error, low_conf;
    logic [DW-1:0]       digit;
    logic signed [R-1:0] max_activation;

    int n_vec = 0;
    int n_err = 0;
    int go_cnt = 0;

    int nom[N]  = '{-5, 3, 12, 7, 100, -128, 99, 0, 1, 2};
    int tie[N]  = '{-20, -20, -20, -1, -20, -20, -20, -20, -1, -20};
    int low[N]  = '{-10, -10, 50, -10, 49, -10, -10, -10, -10, -10};

    always #5 clk = ~clk;

    mlp_inference_ctrl #(.OL_NEURONS(N), .RESOLUTION(R), .DIGIT_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .MLP_go(MLP_go),
        .MLP_done(MLP_done), .output_activations(output_activations), .digit(digit),
        .max_activation(max_activation), .result_valid(result_valid), .result_ack(result_ack),
        .error(error), .low_conf(low_conf)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (MLP_go) go_cnt++;
    endtask

    function automatic logic [R*N-1:0] pack(input int v[N]);
        logic [R*N-1:0] r;
        for (int i = 0; i < int'(N); i++) r[R*i +: R] = R'(v[i]);
        return r;
    endfunction

    // Reference: first index holding the largest signed value
    function automatic void ref_argmax(input logic [R*N-1:0] a, output logic [DW-1:0] d,
                                       output logic signed [R-1:0] m);
        logic signed [R-1:0] v;
        d = '0;
        m = a[R-1:0];
        for (int i = 1; i < int'(N); i++) begin
            v = a[R*i +: R];
            if (v > m) begin
                m = v;
                d = DW'(i);
            end
        end
    endfunction

    function automatic logic ref_low_conf(input logic signed [R-1:0] m, input logic e);
`ifdef MLP_CONF_CHECK_EN
        return (m < 8'sd64) && !e;
`else
        return 1'b0;
`endif
    endfunction

    // One inference. dly<0: MLP_done never comes. lat counts from the done cycle (or GO cycle on timeout).
    task automatic run_inf(input logic [R*N-1:0] acts, input int dly, input bit robust,
                           output int lat, output logic [DW-1:0] d, output logic signed [R-1:0] m,
                           output logic e, output logic lc, output bit stable, output bit ok);
        ok = 1'b1;
        stable = 1'b1;
        output_activations = acts;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (robust) MLP_done = 1'b1;
        tick();
        MLP_done = 1'b0;
        lat = 1;
        if (dly >= 0) begin
            while (lat < dly) begin
                if (robust && lat == 2) result_ack = 1'b1;
                tick();
                result_ack = 1'b0;
                lat++;
            end
            MLP_done = 1'b1;
            tick();
            MLP_done = 1'b0;
            lat = 1;
        end
        while (!result_valid && lat < 200) begin
            if (robust && lat == 3) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end
        if (!result_valid) ok = 1'b0;
        d  = digit;
        m  = max_activation;
        e  = error;
        lc = low_conf;
        if (robust) begin
            for (int i = 0; i < 3; i++) begin
                output_activations = R*N'({$urandom, $urandom, $urandom});
                tick();
                if (digit !== d || max_activation !== m || error !== e || !result_valid) stable = 1'b0;
            end
        end
        result_ack = 1'b1;
        start = 1'b1;
        tick();
        result_ack = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; MLP_done = 1'b0; result_ack = 1'b0;
        output_activations = '0;
        repeat (3) tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (MLP_go !== 1'b0) begin n_err++; $display("FAIL reset_go: got %b want 0", MLP_go); end
        n_vec++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        n_vec++; if (error !== 1'b0 || low_conf !== 1'b0) begin n_err++; $display("FAIL reset_flags: got err=%b lc=%b want 0", error, low_conf); end
        n_vec++; if (digit !== '0 || max_activation !== '0) begin n_err++; $display("FAIL reset_result: got d=%0d m=%0d want 0", digit, max_activation); end
        reset = 1'b0; start = 1'b0;
        tick();
        n_vec++; if (MLP_go !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_go: got go=%b busy=%b want 0", MLP_go, busy); end
        go_cnt = 0;
    endtask

    task automatic test_nominal();
        int lat, g0;
        logic [DW-1:0] d, rd;
        logic signed [R-1:0] m, rm;
        logic e, lc;
        bit st, ok;
        g0 = go_cnt;
        ref_argmax(pack(nom), rd, rm);
        run_inf(pack(nom), 5, 1'b0, lat, d, m, e, lc, st, ok);
        repeat (3) tick();
        n_vec++; if (!ok || lat != 11) begin n_err++; $display("FAIL nom_latency: got %0d want 11", lat); end
        n_vec++; if (d !== rd || d !== DW'(4)) begin n_err++; $display("FAIL nom_digit: got %0d want %0d", d, rd); end
        n_vec++; if (m !== rm || m !== 8'sd100) begin n_err++; $display("FAIL nom_max: got %0d want %0d", m, rm); end
        n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL nom_error: got %b want 0", e); end
        n_vec++; if (lc !== ref_low_conf(rm, 1'b0)) begin n_err++; $display("FAIL nom_low_conf: got %b want %b", lc, ref_low_conf(rm, 1'b0)); end
        n_vec++; if (go_cnt - g0 != 1) begin n_err++; $display("FAIL nom_go_count: got %0d want 1", go_cnt - g0); end
        n_vec++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL nom_idle: got valid=%b busy=%b want 0", result_valid, busy); end
        n_vec++; if (digit !== rd || max_activation !== rm) begin n_err++; $display("FAIL nom_retain: got d=%0d m=%0d want d=%0d m=%0d", digit, max_activation, rd, rm); end
    endtask

    task automatic test_tie_negative();
        int lat;
        int allmin[N];
        logic [DW-1:0] d;
        logic signed [R-1:0] m;
        logic e, lc;
        bit st, ok;
        run_inf(pack(tie), 3, 1'b0, lat, d, m, e, lc, st, ok);
        n_vec++; if (!ok || d !== DW'(3) || m !== -8'sd1) begin n_err++; $display("FAIL tie_neg: got d=%0d m=%0d want d=3 m=-1", d, m); end
        for (int i = 0; i < int'(N); i++) allmin[i] = -128;
        run_inf(pack(allmin), 2, 1'b0, lat, d, m, e, lc, st, ok);
        n_vec++; if (!ok || d !== DW'(0) || m !== -8'sd128) begin n_err++; $display("FAIL tie_all_equal: got d=%0d m=%0d want d=0 m=-128", d, m); end
    endtask

    task automatic test_timeout();
        int lat;
        logic [DW-1:0] d;
        logic signed [R-1:0] m;
        logic e, lc;
        bit st, ok;
        run_inf(pack(nom), -1, 1'b0, lat, d, m, e, lc, st, ok);
        n_vec++; if (!ok || lat != int'(TO) + 1) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 1); end
        n_vec++; if (e !== 1'b1 || d !== '0 || m !== '0) begin n_err++; $display("FAIL timeout_result: got e=%b d=%0d m=%0d want e=1 d=0 m=0", e, d, m); end
        n_vec++; if (lc !== 1'b0) begin n_err++; $display("FAIL timeout_low_conf: got %b want 0", lc); end
        n_vec++; if (error !== 1'b0 || result_valid !== 1'b0) begin n_err++; $display("FAIL timeout_ack_clear: got err=%b valid=%b want 0", error, result_valid); end
    endtask

    task automatic test_robust();
        int lat, g0;
        logic [R*N-1:0] a;
        logic [DW-1:0] d, rd;
        logic signed [R-1:0] m, rm;
        logic e, lc;
        bit st, ok;
        a = R*N'({$urandom, $urandom, $urandom});
        ref_argmax(a, rd, rm);
        g0 = go_cnt;
        run_inf(a, 5, 1'b1, lat, d, m, e, lc, st, ok);
        repeat (3) tick();
        n_vec++; if (!ok || lat != 11) begin n_err++; $display("FAIL robust_latency: got %0d want 11", lat); end
        n_vec++; if (d !== rd || m !== rm) begin n_err++; $display("FAIL robust_result: got d=%0d m=%0d want d=%0d m=%0d", d, m, rd, rm); end
        n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL robust_done_stable: got %b want 1", st); end
        n_vec++; if (go_cnt - g0 != 1) begin n_err++; $display("FAIL robust_go_count: got %0d want 1", go_cnt - g0); end
    endtask

    task automatic test_reset_mid_scan();
        int g0;
        g0 = go_cnt;
        output_activations = pack(nom);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        MLP_done = 1'b1; tick(); MLP_done = 1'b0;
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_vec++; if (busy !== 1'b0 || result_valid !== 1'b0 || MLP_go !== 1'b0) begin n_err++; $display("FAIL midscan_reset_ctrl: got busy=%b valid=%b go=%b want 0", busy, result_valid, MLP_go); end
        n_vec++; if (digit !== '0 || max_activation !== '0 || error !== 1'b0) begin n_err++; $display("FAIL midscan_reset_result: got d=%0d m=%0d e=%b want 0", digit, max_activation, error); end
        repeat (15) tick();
        n_vec++; if (go_cnt - g0 != 1 || busy !== 1'b0 || result_valid !== 1'b0) begin n_err++; $display("FAIL midscan_after: got go=%0d busy=%b valid=%b want go=1 idle", go_cnt - g0, busy, result_valid); end
    endtask

    task automatic test_low_conf();
        int lat;
        logic [DW-1:0] d;
        logic signed [R-1:0] m;
        logic e, lc;
        bit st, ok;
        run_inf(pack(low), 4, 1'b0, lat, d, m, e, lc, st, ok);
        n_vec++; if (!ok || d !== DW'(2) || m !== 8'sd50) begin n_err++; $display("FAIL lowconf_result: got d=%0d m=%0d want d=2 m=50", d, m); end
        n_vec++; if (lc !== ref_low_conf(8'sd50, 1'b0)) begin n_err++; $display("FAIL lowconf_flag: got %b want %b", lc, ref_low_conf(8'sd50, 1'b0)); end
        n_vec++; if (low_conf !== 1'b0) begin n_err++; $display("FAIL lowconf_clear: got %b want 0", low_conf); end
    endtask

    task automatic test_random();
        int lat, g0, dly;
        logic [R*N-1:0] a;
        logic [DW-1:0] d, rd;
        logic signed [R-1:0] m, rm;
        logic e, lc;
        bit st, ok;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (it % 3 == 0) a[R*i +: R] = R'($urandom_range(0, 4)) - R'(2);
                else a[R*i +: R] = R'($urandom);
            end
            dly = int'($urandom_range(1, 8));
            ref_argmax(a, rd, rm);
            g0 = go_cnt;
            run_inf(a, dly, 1'b0, lat, d, m, e, lc, st, ok);
            repeat (2) tick();
            n_vec++; if (!ok || lat != int'(N) + 1) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, N + 1); end
            n_vec++; if (d !== rd || m !== rm) begin n_err++; $display("FAIL rand%0d_result: got d=%0d m=%0d want d=%0d m=%0d", it, d, m, rd, rm); end
            n_vec++; if (e !== 1'b0 || lc !== ref_low_conf(rm, 1'b0)) begin n_err++; $display("FAIL rand%0d_flags: got e=%b lc=%b want e=0 lc=%b", it, e, lc, ref_low_conf(rm, 1'b0)); end
            n_vec++; if (go_cnt - g0 != 1) begin n_err++; $display("FAIL rand%0d_go_count: got %0d want 1", it, go_cnt - g0); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_tie_negative();
        test_timeout();
        test_robust();
        test_reset_mid_scan();
        test_low_conf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mlp_inference_ctrl.md
Name: mlp_inference_ctrl

Overview:
Sequencer for the MLP datapath. Takes one-shot start requests from the pixel-averaging front end and issues a single-cycle MLP_go pulse. Waits for MLP_done, with a timeout. Captures the 10 output activations, then runs a serial argmax to produce the recognised digit, held under a valid/ack handshake for the display/readout logic.

Parameters:
OL_NEURONS, 10, number of output-layer neurons scanned by argmax
RESOLUTION, 8, bit width of each signed activation
DIGIT_W, 4, width of digit index output (must satisfy 2^DIGIT_W >= OL_NEURONS)
TIMEOUT, 1024, max cycles in WAIT before error abort (>= 2)
MIN_CONF, 8'sd64, confidence threshold (used only with optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request one inference; sampled only in IDLE
busy  out  1  high in every state except IDLE
MLP_go  out  1  single-cycle launch pulse to MLP (also its input/output register enable)
MLP_done  in  1  MLP result-ready indication
output_activations  in  RESOLUTION*OL_NEURONS  signed activations from MLP; neuron i at bits [RESOLUTION*i +: RESOLUTION]
digit  out  DIGIT_W  index of maximum activation
max_activation  out  RESOLUTION  signed value of winning activation
result_valid  out  1  result available; held until acknowledged
result_ack  in  1  consumer acknowledge
error  out  1  timeout flag, valid while result_valid=1
low_conf  out  1  max_activation < MIN_CONF (optional feature)

Behaviour:
- Reset: state=IDLE; busy, MLP_go, result_valid, error, low_conf = 0; digit = 0; max_activation = 0; capture register, index and timer cleared. Reset in any state aborts immediately. No MLP_go is issued in the cycle after reset.
- FSM states: IDLE, GO, WAIT, SCAN, DONE.
- IDLE: start=1 -> GO. start is ignored in all other states; it is not queued.
- GO: MLP_go=1 for exactly this cycle -> WAIT; timer=0.
- WAIT:
  - MLP_done=1 -> latch all of output_activations into the capture register; idx=0 -> SCAN.
  - Otherwise timer++. If timer==TIMEOUT-1 without done -> DONE with error=1, digit=0, max_activation=0.
  - MLP_done high in the GO cycle is ignored; only WAIT samples it.
- SCAN: one neuron per cycle, idx 0..OL_NEURONS-1.
  - idx=0 loads best=act[0], best_idx=0.
  - Later entries replace best only on strictly greater signed compare. Ties keep the lowest index.
  - After idx=OL_NEURONS-1 -> DONE. The scan always takes exactly OL_NEURONS cycles.
- DONE: result_valid=1. digit, max_activation and error are stable and registered. result_ack=1 -> IDLE next cycle, result_valid cleared. result_ack outside DONE is ignored.
- Latency: start in cycle 0 -> MLP_go in cycle 1; MLP_done seen in cycle k (k>=2) -> result_valid first high in cycle k+OL_NEURONS+1.
- Outputs in DONE are frozen even if output_activations changes. The capture register isolates the scan from the MLP.
- error clears on leaving DONE. digit and max_activation retain their last values in IDLE.
- Back-to-back: start asserted in the same cycle as the DONE->IDLE ack is ignored. A new inference needs start in IDLE.

Optional Feature:
MLP_CONF_CHECK_EN
- Defined: in the cycle DONE is entered, low_conf = (max_activation < MIN_CONF, signed) and !error. Held through DONE, cleared on exit.
- Undefined: low_conf is tied to 0. The port remains so the interface is identical; MIN_CONF is unused.

Test Plan:
- Reset: hold reset 3 cycles with start=1 -> all outputs 0, no MLP_go pulse, busy=0.
- Nominal: start 1 cycle; MLP_done 5 cycles after MLP_go with activations {n0..n9}={-5,3,12,7,100,-128,99,0,1,2} -> exactly one MLP_go pulse, result_valid 11 cycles after done, digit=4, max_activation=100, error=0. Ack -> IDLE.
- Tie and negative: all activations -20 except n3=n8=-1 -> digit=3, max_activation=-1. All equal -128 -> digit=0.
- Timeout: TIMEOUT=16, MLP_done never asserted -> DONE 16 cycles after entering WAIT, error=1, digit=0. Ack clears error.
- Robustness: start pulsed during SCAN, result_ack pulsed in WAIT, activations changed during DONE, reset asserted mid-SCAN -> no extra MLP_go, outputs stable in DONE, reset returns to IDLE with outputs 0.
- Feature (MLP_CONF_CHECK_EN, MIN_CONF=64): max=50 -> low_conf=1. Max=100 -> low_conf=0. Timeout case -> low_conf=0. Macro undefined -> low_conf always 0.
